// File: rtl/pid_pkg.sv
// Shared types and sign-magnitude helpers for the PID sequencer.
package pid_pkg;

  typedef struct packed {
    logic        sign;
    logic [30:0] mag;
  } sm32_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_START,
    ST_WAIT,
    ST_APPLY
  } pid_state_t;

  localparam logic [30:0] MAG_MAX = 31'h7FFF_FFFF;

  function automatic sm32_t sm_neg(sm32_t x);
    sm32_t r;
    r      = x;
    r.sign = ~x.sign;
    return r;
  endfunction

  function automatic logic sm_mag_gt(sm32_t a, sm32_t b);
    return a.mag > b.mag;
  endfunction

  // Both +0 and -0 collapse to all-zeros.
  function automatic sm32_t sm_norm(sm32_t x);
    return (x.mag == 31'd0) ? sm32_t'(32'h0) : x;
  endfunction

endpackage

// File: rtl/pid_seq_if.sv
// Handshake/operand bundle between the PID sequencer and its environment.
interface pid_seq_if;
  import pid_pkg::*;

  logic  en;
  logic  tick;
  sm32_t setpoint;
  sm32_t position;
  sm32_t pid_out;
  logic  pid_done;
  sm32_t error;
  logic  start_calc;
  sm32_t cmd_out;
  logic  cmd_valid;
  logic  busy;
  logic  timeout_err;
  logic  overrun;
  logic  err_sat;

  modport master (
    output en, tick, setpoint, position, pid_out, pid_done,
    input  error, start_calc, cmd_out, cmd_valid, busy, timeout_err, overrun, err_sat
  );

  modport slave (
    input  en, tick, setpoint, position, pid_out, pid_done,
    output error, start_calc, cmd_out, cmd_valid, busy, timeout_err, overrun, err_sat
  );

endinterface

// File: rtl/pid_seq_add32.sv
// Combinational sign-magnitude adder; ovf flags a magnitude carry out of bit 30.
module add32
  import pid_pkg::*;
(
  input  sm32_t a,
  input  sm32_t b,
  output sm32_t sum,
  output logic  ovf
);

  logic [31:0] mag_sum;
  logic [30:0] mag_diff;
  logic        a_big;
  sm32_t       raw;

  always_comb begin
    mag_sum  = {1'b0, a.mag} + {1'b0, b.mag};
    a_big    = !sm_mag_gt(b, a);
    mag_diff = a_big ? (a.mag - b.mag) : (b.mag - a.mag);
    raw      = '0;
    ovf      = 1'b0;
    sum      = '0;
    if (a.sign == b.sign) begin
      ovf      = mag_sum[31];
      raw.sign = a.sign;
      raw.mag  = mag_sum[30:0];
      // On overflow keep the sign even if the truncated magnitude is zero.
      sum      = ovf ? raw : sm_norm(raw);
    end else begin
      raw.sign = a_big ? a.sign : b.sign;
      raw.mag  = mag_diff;
      sum      = sm_norm(raw);
    end
  end

endmodule

// File: rtl/pid_seq.sv
// PID loop sequencer: samples error, kicks the PID, scales/clamps the result to a command.
// Optional slew limiting of the command is built when PID_SEQ_SLEW_EN is defined.
//
// state     | meaning
// ST_IDLE   | waiting for tick with en high
// ST_SAMPLE | registering setpoint - position
// ST_START  | start_calc pulse to the PID
// ST_WAIT   | waiting for pid_done, bounded by TIMEOUT_CYCLES
// ST_APPLY  | computing the new command; cmd_valid follows
module pid_seq
  import pid_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned OUT_SHIFT      = 8,
  parameter logic [30:0] CMD_LIMIT      = 31'h0000_FFFF
`ifdef PID_SEQ_SLEW_EN
  ,
  parameter logic [30:0] SLEW_MAX       = 31'd256
`endif
) (
  input logic       clk,
  input logic       nrst,
  pid_seq_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  pid_state_t  state;
  logic [TW-1:0] wait_cnt;
  sm32_t       err_r;
  sm32_t       cmd_r;
  sm32_t       pid_cap;
  logic        start_r;
  logic        valid_r;
  logic        to_r;
  logic        ov_r;
  logic        sat_r;

  sm32_t       pos_neg;
  sm32_t       err_sum;
  logic        diff_ovf;
  sm32_t       err_clamped;

  assign pos_neg = sm_neg(bus.position);

  add32 u_sub (
    .a   (bus.setpoint),
    .b   (pos_neg),
    .sum (err_sum),
    .ovf (diff_ovf)
  );

  always_comb begin
    err_clamped = err_sum;
    if (diff_ovf) err_clamped.mag = MAG_MAX;
  end

  logic [30:0] shifted;
  logic [30:0] target_mag;
  sm32_t       target;
  sm32_t       cmd_next;

  always_comb begin
    shifted     = pid_cap.mag >> OUT_SHIFT;
    target_mag  = (shifted > CMD_LIMIT) ? CMD_LIMIT : shifted;
    target.sign = pid_cap.sign;
    target.mag  = target_mag;
    target      = sm_norm(target);
  end

`ifdef PID_SEQ_SLEW_EN
  function automatic logic signed [32:0] sm_to_s33(sm32_t x);
    logic signed [32:0] m;
    m = $signed({2'b00, x.mag});
    return x.sign ? -m : m;
  endfunction

  function automatic sm32_t s33_to_sm(logic signed [32:0] v);
    logic [30:0] m;
    sm32_t       r;
    m      = 31'(v[32] ? -v : v);
    r.sign = v[32];
    r.mag  = m;
    return sm_norm(r);
  endfunction

  logic signed [32:0] tgt_s, prev_s, step_s, slew_s, next_s;

  // Signed arithmetic lets a step cross zero without special casing.
  always_comb begin
    tgt_s  = sm_to_s33(target);
    prev_s = sm_to_s33(cmd_r);
    slew_s = $signed({2'b00, SLEW_MAX});
    step_s = tgt_s - prev_s;
    if (step_s > slew_s)       next_s = prev_s + slew_s;
    else if (step_s < -slew_s) next_s = prev_s - slew_s;
    else                       next_s = tgt_s;
    cmd_next = s33_to_sm(next_s);
  end
`else
  assign cmd_next = target;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      err_r    <= '0;
      cmd_r    <= '0;
      pid_cap  <= '0;
      start_r  <= 1'b0;
      valid_r  <= 1'b0;
      to_r     <= 1'b0;
      ov_r     <= 1'b0;
      sat_r    <= 1'b0;
    end else begin
      start_r <= 1'b0;
      valid_r <= 1'b0;
      if (bus.tick && state != ST_IDLE) ov_r <= 1'b1;
      if (!bus.en) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.tick) state <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            err_r   <= err_clamped;
            if (diff_ovf) sat_r <= 1'b1;
            start_r <= 1'b1;
            state   <= ST_START;
          end
          ST_START: begin
            wait_cnt <= TW'(TIMEOUT_CYCLES - 1);
            state    <= ST_WAIT;
          end
          ST_WAIT: begin
            if (bus.pid_done) begin
              pid_cap <= bus.pid_out;
              state   <= ST_APPLY;
            end else if (wait_cnt == '0) begin
              to_r  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
          ST_APPLY: begin
            cmd_r   <= cmd_next;
            valid_r <= 1'b1;
            state   <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.error       = err_r;
  assign bus.start_calc  = start_r;
  assign bus.cmd_out     = cmd_r;
  assign bus.cmd_valid   = valid_r;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.timeout_err = to_r;
  assign bus.overrun     = ov_r;
  assign bus.err_sat     = sat_r;

endmodule

// File: tb/tb_pid_seq.sv
// Directed bench for pid_seq with a timestamp-based reference model and per-cycle compare.
module tb_pid_seq;
  import pid_pkg::*;

  localparam int    TO        = 64;
  localparam int    SHIFT     = 8;
  localparam longint LIMIT    = 64'h0000_FFFF;
  localparam longint MAXMAG   = 64'h7FFF_FFFF;
`ifdef PID_SEQ_SLEW_EN
  localparam longint SLEW     = 256;
`else
  localparam longint SLEW     = 64'h0000_0100_0000_0000;
`endif

  logic clk;
  logic nrst;
  pid_seq_if bus ();

  pid_seq dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_valid = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint sm2i(logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] i2sm(longint v);
    longint m;
    m = (v < 0) ? -v : v;
    if (m == 0) return 32'h0;
    return {(v < 0), m[30:0]};
  endfunction

  function automatic logic [31:0] cmd_model(logic [31:0] pid, logic [31:0] prev);
    longint mag, tgt, p;
    mag = longint'(pid[30:0]) >>> SHIFT;
    if (mag > LIMIT) mag = LIMIT;
    tgt = pid[31] ? -mag : mag;
    p   = sm2i(prev);
    if (tgt - p > SLEW) tgt = p + SLEW;
    else if (tgt - p < -SLEW) tgt = p - SLEW;
    return i2sm(tgt);
  endfunction

  // Model: an accepted tick at cycle t0 makes the sequence a function of (cycle - t0).
  logic        e_busy, e_start, e_valid, e_to, e_ov, e_sat;
  logic [31:0] e_err, e_cmd, m_cmd;
  longint      m_cyc, m_t0, rel, m_apply_rel, diff;
  logic        m_active;

  initial begin
    {e_busy, e_start, e_valid, e_to, e_ov, e_sat, m_active} = '0;
    e_err = '0; e_cmd = '0; m_cmd = '0;
    m_cyc = 0; m_t0 = 0; m_apply_rel = 0;
  end

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      {e_busy, e_start, e_valid, e_to, e_ov, e_sat, m_active} = '0;
      e_err = '0; e_cmd = '0; m_apply_rel = 0;
    end else begin
      e_start = 1'b0;
      e_valid = 1'b0;
      if (m_active && bus.tick) e_ov = 1'b1;
      if (!bus.en) begin
        m_active = 1'b0;
      end else if (m_active) begin
        rel = m_cyc - m_t0;
        if (m_apply_rel != 0 && rel == m_apply_rel) begin
          e_valid  = 1'b1;
          e_cmd    = m_cmd;
          m_active = 1'b0;
        end else if (rel == 1) begin
          diff = sm2i(bus.setpoint) - sm2i(bus.position);
          if (diff > MAXMAG)       begin diff = MAXMAG;  e_sat = 1'b1; end
          else if (diff < -MAXMAG) begin diff = -MAXMAG; e_sat = 1'b1; end
          e_err   = i2sm(diff);
          e_start = 1'b1;
        end else if (rel >= 3 && m_apply_rel == 0) begin
          if (bus.pid_done) begin
            m_apply_rel = rel + 1;
            m_cmd       = cmd_model(bus.pid_out, e_cmd);
          end else if (rel == 2 + TO) begin
            e_to     = 1'b1;
            m_active = 1'b0;
          end
        end
      end else if (bus.tick) begin
        m_active    = 1'b1;
        m_t0        = m_cyc;
        m_apply_rel = 0;
      end
      e_busy = m_active;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    chk("busy",        bus.busy,        e_busy);
    chk("start_calc",  bus.start_calc,  e_start);
    chk("cmd_valid",   bus.cmd_valid,   e_valid);
    chk("timeout_err", bus.timeout_err, e_to);
    chk("overrun",     bus.overrun,     e_ov);
    chk("err_sat",     bus.err_sat,     e_sat);
    chk("error",       bus.error,       e_err);
    chk("cmd_out",     bus.cmd_out,     e_cmd);
    if (bus.start_calc === 1'b1) n_start++;
    if (bus.cmd_valid === 1'b1)  n_valid++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] sp, input logic [31:0] pos);
    bus.setpoint = sp;
    bus.position = pos;
    bus.tick     = 1'b1;
    step(1);
    bus.tick     = 1'b0;
    step(1);
  endtask

  task automatic done_op(input int w, input logic [31:0] pid);
    step(w);
    bus.pid_out  = pid;
    bus.pid_done = 1'b1;
    step(1);
    bus.pid_done = 1'b0;
    step(1);
  endtask

  int s0, v0;

  initial begin
    nrst = 1'b0;
    bus.en = 1'b0; bus.tick = 1'b0; bus.pid_done = 1'b0;
    bus.setpoint = '0; bus.position = '0; bus.pid_out = '0;
    step(3);
    chk("rst_cmd", bus.cmd_out, 32'h0);
    chk("rst_busy", bus.busy, 1'b0);
    nrst = 1'b1;
    step(1);
    bus.en = 1'b1;
    step(1);

    // -9000 - (+5000), PID done in the third WAIT cycle
    s0 = n_start; v0 = n_valid;
    start_op(32'h8000_2328, 32'h0000_1388);
    chk("err_neg14000", bus.error, 32'h8000_36B0);
    chk("start_pulse", bus.start_calc, 1'b1);
    done_op(3, 32'h8000_0A00);
    chk("latency_valid", bus.cmd_valid, 1'b1);
    chk("cmd_neg10", bus.cmd_out, 32'h8000_000A);
    step(1);
    chk("valid_one_cycle", bus.cmd_valid, 1'b0);
    chk("one_start", n_start - s0, 1);
    chk("one_valid", n_valid - v0, 1);

    // magnitude overflow saturates the error; command exactly at the limit
    start_op(32'h7FFF_FFF0, 32'h8000_0100);
    chk("err_sat_val", bus.error, 32'h7FFF_FFFF);
    chk("err_sat_flag", bus.err_sat, 1'b1);
    done_op(1, 32'h00FF_FF00);
`ifndef PID_SEQ_SLEW_EN
    chk("cmd_at_limit", bus.cmd_out, 32'h0000_FFFF);
`endif
    step(1);

    // -0 minus +0 gives +0; command above the limit clamps
    start_op(32'h8000_0000, 32'h0000_0000);
    chk("err_zero", bus.error, 32'h0);
    done_op(2, 32'h0100_0000);
`ifndef PID_SEQ_SLEW_EN
    chk("cmd_clamped", bus.cmd_out, 32'h0000_FFFF);
`endif
    step(1);

    // negative sub-LSB result becomes a +0 command
    start_op(32'h0000_0005, 32'h0000_0005);
    done_op(1, 32'h8000_00FF);
`ifndef PID_SEQ_SLEW_EN
    chk("cmd_zero", bus.cmd_out, 32'h0);
`endif
    step(1);

    // PID never answers
    v0 = n_valid;
    start_op(32'h0000_0001, 32'h0000_0002);
    chk("err_neg1", bus.error, 32'h8000_0001);
    step(TO);
    chk("to_still_busy", bus.busy, 1'b1);
    chk("to_not_yet", bus.timeout_err, 1'b0);
    step(1);
    chk("to_flag", bus.timeout_err, 1'b1);
    chk("to_idle", bus.busy, 1'b0);
    chk("to_no_valid", n_valid - v0, 0);
    step(2);

    // second tick inside WAIT
    s0 = n_start;
    start_op(32'h0000_0064, 32'h0000_0000);
    step(2);
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
    chk("overrun_flag", bus.overrun, 1'b1);
    done_op(1, 32'h0000_1200);
    chk("overrun_one_start", n_start - s0, 1);
    step(1);

    // reset while waiting, then a clean operation
    start_op(32'h0000_0020, 32'h0000_0001);
    step(2);
    nrst = 1'b0;
    #1;
    chk("rst_wait_busy", bus.busy, 1'b0);
    chk("rst_wait_err", bus.error, 32'h0);
    chk("rst_wait_cmd", bus.cmd_out, 32'h0);
    chk("rst_wait_sticky", {bus.timeout_err, bus.overrun, bus.err_sat}, 3'b000);
    step(1);
    nrst = 1'b1;
    step(1);
    start_op(32'h0000_0010, 32'h0000_0004);
    chk("err_after_rst", bus.error, 32'h0000_000C);
    done_op(2, 32'h0000_0500);
    chk("valid_after_rst", bus.cmd_valid, 1'b1);
    chk("cmd_after_rst", bus.cmd_out, 32'h0000_0005);
    step(1);

    // en dropped in WAIT aborts without a command
    v0 = n_valid;
    start_op(32'h0000_0007, 32'h0000_0003);
    step(2);
    bus.en = 1'b0;
    step(1);
    bus.en = 1'b1;
    step(1);
    bus.pid_out  = 32'h0000_0300;
    bus.pid_done = 1'b1;
    step(1);
    bus.pid_done = 1'b0;
    step(3);
    chk("abort_no_valid", n_valid - v0, 0);
    chk("abort_cmd_held", bus.cmd_out, 32'h0000_0005);
    chk("abort_idle", bus.busy, 1'b0);

`ifdef PID_SEQ_SLEW_EN
    nrst = 1'b0;
    step(1);
    nrst = 1'b1;
    step(1);
    start_op(32'h0000_0001, 32'h0);
    done_op(1, 32'h0003_E800);
    chk("slew_1", bus.cmd_out, 32'h0000_0100);
    step(1);
    start_op(32'h0000_0001, 32'h0);
    done_op(1, 32'h0003_E800);
    chk("slew_2", bus.cmd_out, 32'h0000_0200);
    step(1);
    start_op(32'h0000_0001, 32'h0);
    done_op(1, 32'h0003_E800);
    chk("slew_3", bus.cmd_out, 32'h0000_0300);
    step(1);
    start_op(32'h0000_0001, 32'h0);
    done_op(1, 32'h0003_E800);
    chk("slew_4", bus.cmd_out, 32'h0000_03E8);
    step(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/pid_seq.md
PID_SEQ -- requirements
Module: pid_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: max cycles waited for pid_done before abort.
REQ-002 SHALL have parameter OUT_SHIFT, default 8: right-shift applied to PID output magnitude.
REQ-003 SHALL have parameter CMD_LIMIT, default 31'h0000_FFFF: max command magnitude.
REQ-004 SHALL have clk  input  1  system clock; one clock domain only.
REQ-005 SHALL have nrst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have en  input  1  loop enable; low forces IDLE at the next edge.
REQ-007 SHALL have tick  input  1  control-period strobe, one-cycle pulse.
REQ-008 SHALL have setpoint, position  input  32 each  sign-magnitude operands; bit 31 is the sign.
REQ-009 SHALL have pid_out  input  32  sign-magnitude PID result.
REQ-010 SHALL have pid_done  input  1  PID result valid.
REQ-011 SHALL have error  output  32  sign-magnitude error to the PID.
REQ-012 SHALL have start_calc  output  1  one-cycle PID start pulse.
REQ-013 SHALL have cmd_out  output  32  sign-magnitude actuator command.
REQ-014 SHALL have cmd_valid  output  1  one-cycle command strobe.
REQ-015 SHALL have busy, timeout_err, overrun, err_sat  output  1 each  status; the last three are sticky.

Function
REQ-016 SHALL implement FSM IDLE->SAMPLE->START->WAIT->APPLY->IDLE.
REQ-017 SHALL leave IDLE only on tick=1 with en=1.
REQ-018 SHALL in SAMPLE register error = setpoint - position in sign-magnitude.
REQ-019 SHALL on magnitude overflow clamp error to magnitude 31'h7FFF_FFFF and set err_sat.
REQ-020 SHALL normalize a zero result (-0 or +0) to 32'h0.
REQ-021 SHALL hold error stable from SAMPLE until return to IDLE.
REQ-022 SHALL assert start_calc for exactly the one START cycle.
REQ-023 SHALL in WAIT advance to APPLY on the first cycle pid_done=1.
REQ-024 SHALL, if TIMEOUT_CYCLES WAIT cycles elapse with no pid_done, set timeout_err, go to IDLE, and emit no cmd_valid.
REQ-025 SHALL in APPLY set cmd_out sign = pid_out[31] and magnitude = min(pid_out[30:0] >> OUT_SHIFT, CMD_LIMIT).
REQ-026 SHALL pulse cmd_valid for one cycle, in APPLY, with that new cmd_out.
REQ-027 SHALL force a zero-magnitude command to 32'h0.
REQ-028 SHALL hold cmd_out between updates.
REQ-029 SHALL ignore a tick arriving outside IDLE and set overrun.
REQ-030 SHALL, on en=0 in any state, abort to IDLE without cmd_valid; cmd_out is held.
REQ-031 SHALL assert busy whenever the state is not IDLE.
REQ-032 SHALL give a tick-to-cmd_valid latency of 4 + (WAIT cycles) clocks.

Reset
REQ-033 SHALL on nrst=0 go immediately to IDLE and zero all outputs and sticky flags; mid-operation reset discards the cycle in progress.
REQ-034 SHALL clear sticky flags only by reset.

Configuration
REQ-035 SHALL, with PID_SEQ_SLEW_EN defined, limit |cmd_new - cmd_prev| per APPLY to parameter SLEW_MAX (default 256), stepping toward the target across zero correctly.
REQ-036 SHALL, without PID_SEQ_SLEW_EN, apply REQ-025 directly, with no SLEW_MAX parameter and no slew logic.

Structure
REQ-037 SHALL take the sm32_t typedef, the state enum, and sign-magnitude negate/compare functions from shared package pid_pkg.
REQ-038 SHALL compute the subtraction with one instance of the existing add32 sub-module (position sign inverted), using its overflow to detect saturation.

Verification
REQ-039 SHALL test: setpoint=-9000, position=+5000, tick -> error=0x8000_36B0 (-14000) and one start_calc pulse.
REQ-040 SHALL test: pid_out=0x8000_0A00, pid_done -> cmd_out=0x8000_000A, cmd_valid for one cycle.
REQ-041 SHALL test: setpoint=+0x7FFF_FFF0, position=-0x100 -> error=0x7FFF_FFFF, err_sat=1.
REQ-042 SHALL test: pid_done held low -> timeout_err=1 after 64 WAIT cycles, FSM in IDLE, no cmd_valid.
REQ-043 SHALL test: second tick during WAIT -> overrun=1, single start_calc; nrst low in WAIT -> all outputs 0, and the next tick works normally.
REQ-044 SHALL test: with PID_SEQ_SLEW_EN, cmd_prev=0 and target=+1000 -> successive cmds 256, 512, 768, 1000.
